mod6_seq_monitor: RTL and testbench



---
 rtl/mod6_seq_monitor_if.sv | 39 +++
 rtl/mod6_seq_monitor.sv | 133 +++++++++++++
 tb/tb_mod6_seq_monitor.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/mod6_seq_monitor_if.sv
// Bundle of signals between the upstream counter side and the mod-6 sequence monitor.
// With MOD6_SEQ_MON_CAPTURE_EN defined it also carries the captured bad/expected values.
interface mod6_seq_monitor_if #(
  parameter int COUNT_W = 3,
  parameter int WRAP_W  = 8
);
  logic [COUNT_W-1:0] count;
  logic               clr;
  logic               locked;
  logic               wrap_pulse;
  logic [WRAP_W-1:0]  wrap_count;
  logic               wrap_ovf;
  logic               err;
  logic [1:0]         err_code;
`ifdef MOD6_SEQ_MON_CAPTURE_EN
  logic [COUNT_W-1:0] bad_value;
  logic [COUNT_W-1:0] exp_value;
`endif

`ifdef MOD6_SEQ_MON_CAPTURE_EN
  modport master (
    output count, clr,
    input  locked, wrap_pulse, wrap_count, wrap_ovf, err, err_code, bad_value, exp_value
  );
  modport slave (
    input  count, clr,
    output locked, wrap_pulse, wrap_count, wrap_ovf, err, err_code, bad_value, exp_value
  );
`else
  modport master (
    output count, clr,
    input  locked, wrap_pulse, wrap_count, wrap_ovf, err, err_code
  );
  modport slave (
    input  count, clr,
    output locked, wrap_pulse, wrap_count, wrap_ovf, err, err_code
  );
`endif
endinterface

// File: rtl/mod6_seq_monitor.sv
// Checks that an upstream mod-MOD counter steps 0..MOD-1 by one per cycle, counts wraps, flags errors.
// Optional macro MOD6_SEQ_MON_CAPTURE_EN adds capture of the offending and expected values.
module mod6_seq_monitor #(
  parameter int COUNT_W = 3,
  parameter int MOD     = 6,
  parameter int WRAP_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  mod6_seq_monitor_if.slave   bus
);

  typedef enum logic [1:0] {SYNC, TRACK, ERROR} state_t;

  localparam logic [COUNT_W-1:0] LAST = COUNT_W'(MOD - 1);

  localparam logic [1:0] CODE_NONE    = 2'b00;
  localparam logic [1:0] CODE_ILLEGAL = 2'b01;
  localparam logic [1:0] CODE_SKIP    = 2'b10;
  localparam logic [1:0] CODE_STALL   = 2'b11;

  state_t             state_q;
  logic [COUNT_W-1:0] prev_q;
  logic               locked_q;
  logic               wrapPulse_q;
  logic [WRAP_W-1:0]  wrapCount_q;
  logic               wrapOvf_q;
  logic               err_q;
  logic [1:0]         errCode_q;
`ifdef MOD6_SEQ_MON_CAPTURE_EN
  logic [COUNT_W-1:0] badValue_q;
  logic [COUNT_W-1:0] expValue_q;
`endif

  logic [COUNT_W-1:0] expected_d;
  logic               illegal_d;

  assign expected_d = (prev_q == LAST) ? '0 : prev_q + 1'b1;
  assign illegal_d  = (count_ext(bus.count) >= MOD);

  function automatic int count_ext(input logic [COUNT_W-1:0] v);
    return int'(v);
  endfunction

  // clr clears the accumulators unconditionally; a wrap in the same cycle still pulses but is not counted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SYNC;
      prev_q      <= '0;
      locked_q    <= 1'b0;
      wrapPulse_q <= 1'b0;
      wrapCount_q <= '0;
      wrapOvf_q   <= 1'b0;
      err_q       <= 1'b0;
      errCode_q   <= CODE_NONE;
`ifdef MOD6_SEQ_MON_CAPTURE_EN
      badValue_q  <= '0;
      expValue_q  <= '0;
`endif
    end else begin
      wrapPulse_q <= 1'b0;
      if (bus.clr) begin
        wrapCount_q <= '0;
        wrapOvf_q   <= 1'b0;
      end
      case (state_q)
        SYNC: begin
          if (illegal_d) begin
            state_q   <= ERROR;
            locked_q  <= 1'b0;
            err_q     <= 1'b1;
            errCode_q <= CODE_ILLEGAL;
`ifdef MOD6_SEQ_MON_CAPTURE_EN
            badValue_q <= bus.count;
            expValue_q <= '0;
`endif
          end else begin
            state_q  <= TRACK;
            prev_q   <= bus.count;
            locked_q <= 1'b1;
          end
        end
        TRACK: begin
          if (illegal_d || bus.count != expected_d) begin
            state_q  <= ERROR;
            locked_q <= 1'b0;
            err_q    <= 1'b1;
            if (illegal_d)                 errCode_q <= CODE_ILLEGAL;
            else if (bus.count == prev_q)  errCode_q <= CODE_STALL;
            else                           errCode_q <= CODE_SKIP;
`ifdef MOD6_SEQ_MON_CAPTURE_EN
            badValue_q <= bus.count;
            expValue_q <= expected_d;
`endif
          end else begin
            prev_q <= bus.count;
            if (prev_q == LAST) begin
              wrapPulse_q <= 1'b1;
              if (!bus.clr) begin
                wrapCount_q <= wrapCount_q + 1'b1;
                if (&wrapCount_q) wrapOvf_q <= 1'b1;
              end
            end
          end
        end
        ERROR: begin
          if (bus.clr) begin
            state_q   <= SYNC;
            err_q     <= 1'b0;
            errCode_q <= CODE_NONE;
`ifdef MOD6_SEQ_MON_CAPTURE_EN
            badValue_q <= '0;
            expValue_q <= '0;
`endif
          end
        end
        default: state_q <= SYNC;
      endcase
    end
  end

  assign bus.locked     = locked_q;
  assign bus.wrap_pulse = wrapPulse_q;
  assign bus.wrap_count = wrapCount_q;
  assign bus.wrap_ovf   = wrapOvf_q;
  assign bus.err        = err_q;
  assign bus.err_code   = errCode_q;
`ifdef MOD6_SEQ_MON_CAPTURE_EN
  assign bus.bad_value  = badValue_q;
  assign bus.exp_value  = expValue_q;
`endif

endmodule

// File: tb/tb_mod6_seq_monitor.sv
// Directed bench for mod6_seq_monitor: a WRAP_W=8 instance plus a WRAP_W=2 instance for overflow.
module tb_mod6_seq_monitor;

  logic       clk;
  logic       rst_n;
  logic [2:0] countDrv;
  logic       clrDrv;
  int         numAsserts;
  int         numFails;

  mod6_seq_monitor_if #(.COUNT_W(3), .WRAP_W(8)) busMain ();
  mod6_seq_monitor_if #(.COUNT_W(3), .WRAP_W(2)) busSmall ();

  assign busMain.count  = countDrv;
  assign busMain.clr    = clrDrv;
  assign busSmall.count = countDrv;
  assign busSmall.clr   = clrDrv;

  mod6_seq_monitor #(.COUNT_W(3), .MOD(6), .WRAP_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busMain.slave)
  );

  mod6_seq_monitor #(.COUNT_W(3), .MOD(6), .WRAP_W(2)) dutSmall (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busSmall.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // drive one sample, let the edge take it, then settle past the edge
  task automatic applyStimulus(input logic [2:0] c, input logic cl);
    countDrv = c;
    clrDrv   = cl;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    numAsserts++;
    assert (observed === expected)
      else begin
        numFails++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  task automatic checkMain(input string tag, input logic lk, input logic wp, input logic [7:0] wc,
                           input logic er, input logic [1:0] ec);
    checkOutput({tag, ".locked"},     32'(busMain.locked),     32'(lk));
    checkOutput({tag, ".wrap_pulse"}, 32'(busMain.wrap_pulse), 32'(wp));
    checkOutput({tag, ".wrap_count"}, 32'(busMain.wrap_count), 32'(wc));
    checkOutput({tag, ".err"},        32'(busMain.err),        32'(er));
    checkOutput({tag, ".err_code"},   32'(busMain.err_code),   32'(ec));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    numAsserts = 0;
    numFails   = 0;
    rst_n      = 1'b0;
    countDrv   = 3'd0;
    clrDrv     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkMain("reset", 1'b0, 1'b0, 8'd0, 1'b0, 2'b00);
    checkOutput("reset.wrap_ovf", 32'(busMain.wrap_ovf), 32'd0);
    rst_n = 1'b1;

    // clean upstream counter: 0,1,..,5,0,... for 30 samples
    for (int i = 0; i < 30; i++) begin
      applyStimulus(3'(i % 6), 1'b0);
      checkOutput($sformatf("clean%0d.locked", i), 32'(busMain.locked), 32'd1);
      checkOutput($sformatf("clean%0d.wrap_pulse", i), 32'(busMain.wrap_pulse),
                  32'((i > 0) && (i % 6 == 0)));
      checkOutput($sformatf("clean%0d.err", i), 32'(busMain.err), 32'd0);
      if (i == 18) begin
        checkOutput("small18.wrap_count", 32'(busSmall.wrap_count), 32'd3);
        checkOutput("small18.wrap_ovf", 32'(busSmall.wrap_ovf), 32'd0);
      end
    end
    checkOutput("clean.wrap_count", 32'(busMain.wrap_count), 32'd4);
    checkOutput("clean.wrap_ovf", 32'(busMain.wrap_ovf), 32'd0);
    checkOutput("small.wrap_count", 32'(busSmall.wrap_count), 32'd0);
    checkOutput("small.wrap_ovf", 32'(busSmall.wrap_ovf), 32'd1);

    applyStimulus(3'd0, 1'b0);
    checkMain("wrap5", 1'b1, 1'b1, 8'd5, 1'b0, 2'b00);
    checkOutput("small5.wrap_count", 32'(busSmall.wrap_count), 32'd1);
    checkOutput("small5.wrap_ovf", 32'(busSmall.wrap_ovf), 32'd1);
    applyStimulus(3'd1, 1'b0);

    applyStimulus(3'd7, 1'b0);
    checkMain("illegal", 1'b0, 1'b0, 8'd5, 1'b1, 2'b01);
`ifdef MOD6_SEQ_MON_CAPTURE_EN
    checkOutput("illegal.bad_value", 32'(busMain.bad_value), 32'd7);
    checkOutput("illegal.exp_value", 32'(busMain.exp_value), 32'd2);
`endif
    applyStimulus(3'd2, 1'b0);
    checkMain("illegalHold", 1'b0, 1'b0, 8'd5, 1'b1, 2'b01);
    checkOutput("smallHold.wrap_ovf", 32'(busSmall.wrap_ovf), 32'd1);

    applyStimulus(3'd3, 1'b1);
    checkMain("clrErr", 1'b0, 1'b0, 8'd0, 1'b0, 2'b00);
    checkOutput("clrErr.small_ovf", 32'(busSmall.wrap_ovf), 32'd0);
`ifdef MOD6_SEQ_MON_CAPTURE_EN
    checkOutput("clrErr.bad_value", 32'(busMain.bad_value), 32'd0);
`endif
    applyStimulus(3'd4, 1'b0);
    checkMain("relock", 1'b1, 1'b0, 8'd0, 1'b0, 2'b00);
    applyStimulus(3'd5, 1'b0);
    applyStimulus(3'd0, 1'b0);
    checkMain("relockWrap", 1'b1, 1'b1, 8'd1, 1'b0, 2'b00);

    // stall: ... 2,3,3
    applyStimulus(3'd1, 1'b0);
    applyStimulus(3'd2, 1'b0);
    applyStimulus(3'd3, 1'b0);
    applyStimulus(3'd3, 1'b0);
    checkMain("stall", 1'b0, 1'b0, 8'd1, 1'b1, 2'b11);
`ifdef MOD6_SEQ_MON_CAPTURE_EN
    checkOutput("stall.bad_value", 32'(busMain.bad_value), 32'd3);
    checkOutput("stall.exp_value", 32'(busMain.exp_value), 32'd4);
`endif
    applyStimulus(3'd0, 1'b1);
    checkMain("clrStall", 1'b0, 1'b0, 8'd0, 1'b0, 2'b00);

    // skip: 1,2,4
    applyStimulus(3'd1, 1'b0);
    applyStimulus(3'd2, 1'b0);
    applyStimulus(3'd4, 1'b0);
    checkMain("skip", 1'b0, 1'b0, 8'd0, 1'b1, 2'b10);
`ifdef MOD6_SEQ_MON_CAPTURE_EN
    checkOutput("skip.bad_value", 32'(busMain.bad_value), 32'd4);
    checkOutput("skip.exp_value", 32'(busMain.exp_value), 32'd3);
`endif
    applyStimulus(3'd0, 1'b1);

    // clr coinciding with a legal wrap: pulse fires, count cleared
    applyStimulus(3'd4, 1'b0);
    applyStimulus(3'd5, 1'b0);
    applyStimulus(3'd0, 1'b0);
    for (int v = 1; v <= 5; v++) applyStimulus(3'(v), 1'b0);
    checkMain("preClrWrap", 1'b1, 1'b0, 8'd1, 1'b0, 2'b00);
    applyStimulus(3'd0, 1'b1);
    checkMain("clrWrap", 1'b1, 1'b1, 8'd0, 1'b0, 2'b00);

    // clr coinciding with a violation: error recorded, counters cleared
    for (int v = 1; v <= 5; v++) applyStimulus(3'(v), 1'b0);
    applyStimulus(3'd0, 1'b0);
    checkMain("preClrViol", 1'b1, 1'b1, 8'd1, 1'b0, 2'b00);
    applyStimulus(3'd2, 1'b1);
    checkMain("clrViol", 1'b0, 1'b0, 8'd0, 1'b1, 2'b10);

    // asynchronous reset with err=1, checked before any further edge
    #2;
    rst_n = 1'b0;
    #1;
    checkMain("asyncRst", 1'b0, 1'b0, 8'd0, 1'b0, 2'b00);
    checkOutput("asyncRst.wrap_ovf", 32'(busMain.wrap_ovf), 32'd0);
    #2;
    rst_n = 1'b1;
    applyStimulus(3'd0, 1'b0);
    checkMain("postRst0", 1'b1, 1'b0, 8'd0, 1'b0, 2'b00);
    applyStimulus(3'd1, 1'b0);
    checkMain("postRst1", 1'b1, 1'b0, 8'd0, 1'b0, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", numAsserts, numFails);
    $finish;
  end

endmodule
